exec_alu: RTL and testbench
===========================

# exec_alu

Parametrised execute-stage ALU with a valid/ready handshake on both sides. It accepts operands, a pass-through value and the instruction word from decode, and executes RV32I-style integer operations selected by `itype_i` and the funct fields of `ir_i`. It returns a registered result and the pass-through value to the memory/writeback stage. Shifts run on an iterative shifter so the unit can stall decode; every other operation completes in one cycle.

## Interface
- `XLEN`, default 32: datapath width. Must be a power of 2 and at least 8.
- `SHIFT_STEP`, default 1: bit positions shifted per cycle. Must be a power of 2 and ≤ XLEN/2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  decode presents an operation.
- `in_ready_o`  out  1  unit accepts an operation this cycle.
- `a_i`  in  XLEN  operand A (rs1 or PC).
- `b_i`  in  XLEN  operand B (rs2, or the immediate already sign-extended/shifted by decode).
- `pass_i`  in  XLEN  pass-through value (store data/return address).
- `ir_i`  in  32  instruction word.
- `itype_i`  in  5  instruction format code, from the shared format constants.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream consumes the result.
- `y_o`  out  XLEN  result.
- `pass_o`  out  XLEN  registered copy of `pass_i`.
- `busy_o`  out  1  shift in progress.

## Operation
- An operation is accepted when `in_valid_i && in_ready_o` are both high. At acceptance, `pass_i`, `a_i`, `b_i` and the decoded op are captured.
- **RTYPE**, selected by funct3 = `ir_i[14:12]`, with `ir_i[30]` as the modifier:
  - ADD/SUB
  - SLL, SLT (signed), SLTU
  - XOR
  - SRL/SRA
  - OR, AND
- **ITYPE**: same op set with B as the immediate.
  - funct3=000 is always ADD; `ir_i[30]` is ignored.
  - `ir_i[30]` selects SRAI only when funct3=101.
- **UTYPE**: `ir_i[5]`=1 (LUI) gives y=B; `ir_i[5]`=0 (AUIPC) gives y=A+B.
- **All other formats**: y=A+B (address generation).
- Arithmetic rules:
  - Add/sub wrap modulo 2^XLEN.
  - SLT/SLTU give 1 or 0, zero-extended to XLEN.
  - SRA fills with A[XLEN-1].
  - shamt = B[$clog2(XLEN)-1:0]; upper bits of B are ignored.
- **FSM states: IDLE, SHIFT, DONE.**
  - IDLE, on accept of a non-shift op: compute, go to DONE.
  - IDLE, on accept of a shift with shamt=0: y=A, go to DONE.
  - IDLE, on accept of a shift with shamt≠0: go to SHIFT with remaining=shamt.
  - SHIFT, each cycle: shift by min(SHIFT_STEP, remaining) and decrement remaining. When remaining reaches 0, go to DONE.
  - DONE: `out_valid_o`=1, and `y_o`/`pass_o` are held stable until `out_ready_i`.
    - On the handshake, if a new op is accepted in the same cycle, process it as from IDLE.
    - Otherwise go to IDLE.
- `in_ready_o` = (state==IDLE) || (state==DONE && `out_ready_i`). It is 0 in SHIFT.
- `busy_o` = (state==SHIFT).
- Reset:
  - state=IDLE.
  - `y_o`, `pass_o`, `out_valid_o` and `busy_o` are all 0.
  - A reset during SHIFT or DONE abandons the operation with no output.
- Inputs with `in_valid_i`=0 are ignored, and X on unused inputs must not propagate.

## Timing
- Non-shift op accepted at cycle T: `out_valid_o`=1 from T+1.
- Shift accepted at T: `out_valid_o`=1 from T+1+ceil(shamt/SHIFT_STEP). shamt=0 gives T+1.
- Back-to-back non-shift ops with `out_ready_i` held high sustain 1 op/cycle.
- If `out_ready_i`=0 in DONE, the outputs hold indefinitely and `in_ready_o`=0.
- All outputs are registered except `in_ready_o`, which is combinational from state and `out_ready_i`.

## Structure
- Shared package `alu_pkg`, holding:
  - the op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB;
  - the funct3 constants;
  - the FSM state type.
- The existing format constants (RTYPE/ITYPE/STYPE/BTYPE/UTYPE/JTYPE) stay in the shared format header and are reused unchanged.
- Sub-module `alu_shifter`, parametrised by XLEN and SHIFT_STEP:
  - load/step interface;
  - holds the working value and the remaining count;
  - raises `done` when remaining=0.
- The decode of `itype_i`/`ir_i` to op is a combinational function in the top module.

## Test plan
- ADD, RTYPE, XLEN=32: A=0xFFFFFFFF, B=1 -> y=0 at T+1. SUB (`ir_i[30]`=1) with A=0, B=1 -> y=0xFFFFFFFF.
- SLT vs SLTU: A=0xFFFFFFFF, B=1 -> SLT y=1, SLTU y=0. ADDI with `ir_i[30]`=1 -> still an add.
- SRA, SHIFT_STEP=1: A=0x80000000, shamt=4 -> `busy_o` high for 4 cycles, y=0xF8000000 valid at T+5. With SHIFT_STEP=4, valid at T+2. shamt=0 -> y=A at T+1.
- UTYPE: LUI (`ir_i[5]`=1), B=0x12345000 -> y=0x12345000. AUIPC, A=0x100, B=0x1000 -> y=0x1100. `pass_o` equals `pass_i` captured at accept.
- Backpressure: `out_ready_i`=0 for 3 cycles -> `y_o`/`out_valid_o` stable and `in_ready_o`=0. Then stream 4 ADDs with `out_ready_i`=1 -> 4 results on 4 consecutive cycles.
- Reset asserted mid-SHIFT -> next cycle: state IDLE, `out_valid_o`=0, `busy_o`=0, `y_o`=0. The subsequent op executes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: ALU op encoding, funct3 constants and FSM state type for exec_alu.
// Latency: none; types and constants only.
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_PASSB
    } alu_op_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } alu_state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/rv_format_pkg.sv
// Purpose: instruction format codes shared by decode and the execute stage.
// Latency: none; constants only.
// Backpressure: not applicable.
package rv_format_pkg;

    localparam logic [4:0] RTYPE = 5'd0;
    localparam logic [4:0] ITYPE = 5'd1;
    localparam logic [4:0] STYPE = 5'd2;
    localparam logic [4:0] BTYPE = 5'd3;
    localparam logic [4:0] UTYPE = 5'd4;
    localparam logic [4:0] JTYPE = 5'd5;

endpackage

// File: rtl/alu_shifter.sv
// Purpose: iterative shifter, SHIFT_STEP bit positions per step (last step may be shorter).
// Latency: ceil(amount/SHIFT_STEP) steps after load.
// Backpressure: advances only while step is high; holds value otherwise.
// Ports: load/load_* start an operation; step advances it; value_o/next_value expose the
//        working value now and after this step; final_step flags the step that finishes;
//        done is high while remaining is zero.
module alu_shifter #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    localparam int CW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_value,
    input  logic [CW-1:0]   load_amount,
    input  logic            load_left,
    input  logic            load_arith,
    input  logic            step,
    output logic [XLEN-1:0] value_o,
    output logic [XLEN-1:0] next_value,
    output logic            final_step,
    output logic            done
);

    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    logic [XLEN-1:0] value_q;
    logic [CW-1:0]   remaining_q;
    logic            left_q;
    logic            arith_q;
    logic [CW-1:0]   step_amt;

    // The last step covers whatever is left over when shamt is not a multiple of SHIFT_STEP.
    assign step_amt = (remaining_q > STEP_C) ? STEP_C : remaining_q;

    always_comb begin
        next_value = value_q;
        if (left_q) begin
            next_value = value_q << step_amt;
        end else if (arith_q) begin
            next_value = $unsigned($signed(value_q) >>> step_amt);
        end else begin
            next_value = value_q >> step_amt;
        end
    end

    assign value_o    = value_q;
    assign done       = (remaining_q == '0);
    assign final_step = (remaining_q <= STEP_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q     <= '0;
            remaining_q <= '0;
            left_q      <= 1'b0;
            arith_q     <= 1'b0;
        end else if (load) begin
            value_q     <= load_value;
            remaining_q <= load_amount;
            left_q      <= load_left;
            arith_q     <= load_arith;
        end else if (step && !done) begin
            value_q     <= next_value;
            remaining_q <= remaining_q - step_amt;
        end
    end

endmodule

// File: rtl/exec_alu.sv
// Purpose: execute-stage integer ALU (RV32I ops) with valid/ready on both sides.
// Latency: 1 cycle for non-shifts; shifts 1 + ceil(shamt/SHIFT_STEP) cycles.
// Backpressure: result held in DONE until out_ready_i; in_ready_o low while shifting or stalled.
// Ports: in_valid_i/in_ready_o accept a_i, b_i, pass_i, ir_i, itype_i; out_valid_o/out_ready_i
//        return y_o and pass_o; busy_o is high while the shifter is iterating.
// XLEN must be a power of 2 >= 8; SHIFT_STEP a power of 2 <= XLEN/2.
module exec_alu
    import rv_format_pkg::*;
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] pass_i,
    input  logic [31:0]     ir_i,
    input  logic [4:0]      itype_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] y_o,
    output logic [XLEN-1:0] pass_o,
    output logic            busy_o
);

    localparam int SW = $clog2(XLEN);

    function automatic alu_op_t decode_op(input logic [4:0] itype, input logic [2:0] f3,
                                          input logic bit30, input logic bit5);
        alu_op_t op;
        op = OP_ADD;
        case (itype)
            RTYPE, ITYPE: begin
                case (f3)
                    // Immediate adds have no SUB form; bit 30 is part of the immediate.
                    F3_ADD:  op = (itype == RTYPE && bit30) ? OP_SUB : OP_ADD;
                    F3_SLL:  op = OP_SLL;
                    F3_SLT:  op = OP_SLT;
                    F3_SLTU: op = OP_SLTU;
                    F3_XOR:  op = OP_XOR;
                    F3_SR:   op = bit30 ? OP_SRA : OP_SRL;
                    F3_OR:   op = OP_OR;
                    F3_AND:  op = OP_AND;
                    default: op = OP_ADD;
                endcase
            end
            UTYPE:   op = bit5 ? OP_PASSB : OP_ADD;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Shifts reaching here have shamt == 0, so the result is A unchanged.
    function automatic logic [XLEN-1:0] alu_compute(input alu_op_t op, input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [XLEN-1:0] y;
        y = a + b;
        case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:   y = a ^ b;
            OP_OR:    y = a | b;
            OP_AND:   y = a & b;
            OP_PASSB: y = b;
            OP_SLL, OP_SRL, OP_SRA: y = a;
            default:  y = a + b;
        endcase
        return y;
    endfunction

    alu_state_t      state_q, state_d;
    alu_op_t         op_dec;
    logic [SW-1:0]   shamt;
    logic            accept;
    logic            start_shift;
    logic [XLEN-1:0] y_q, pass_q;
    logic [XLEN-1:0] sh_value, sh_next;
    logic            sh_final, sh_done;

    logic unused_ir;
    assign unused_ir = &{1'b0, ir_i[31], ir_i[29:15], ir_i[11:6], ir_i[4:0]};

    assign op_dec      = decode_op(itype_i, ir_i[14:12], ir_i[30], ir_i[5]);
    assign shamt       = b_i[SW-1:0];
    assign in_ready_o  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign start_shift = accept && is_shift_op(op_dec) && (shamt != '0);

    alu_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (start_shift),
        .load_value  (a_i),
        .load_amount (shamt),
        .load_left   (op_dec == OP_SLL),
        .load_arith  (op_dec == OP_SRA),
        .step        (state_q == ST_SHIFT),
        .value_o     (sh_value),
        .next_value  (sh_next),
        .final_step  (sh_final),
        .done        (sh_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = start_shift ? ST_SHIFT : ST_DONE;
                end else if (state_q == ST_DONE && !out_ready_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Leave on the step that empties the count so the result lands with no bubble.
                if (sh_final || sh_done) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q    <= '0;
            pass_q <= '0;
        end else if (accept) begin
            pass_q <= pass_i;
            if (!start_shift) begin
                y_q <= alu_compute(op_dec, a_i, b_i);
            end
        end else if (state_q == ST_SHIFT && (sh_final || sh_done)) begin
            y_q <= sh_done ? sh_value : sh_next;
        end
    end

    assign y_o         = y_q;
    assign pass_o      = pass_q;
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_exec_alu.sv
module tb_exec_alu;
    import rv_format_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        en4;
    logic [31:0] a, b, pass, ir;
    logic [4:0]  itype;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [31:0] y, pass_out;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] y4, pass_out4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exec_alu #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .pass_i(pass), .ir_i(ir), .itype_i(itype),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .y_o(y), .pass_o(pass_out), .busy_o(busy)
    );

    exec_alu #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid_i(in_valid && en4), .in_ready_o(in_ready4),
        .a_i(a), .b_i(b), .pass_i(pass), .ir_i(ir), .itype_i(itype),
        .out_valid_o(out_valid4), .out_ready_i(out_ready),
        .y_o(y4), .pass_o(pass_out4), .busy_o(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [2:0] f3, input logic b30, input logic b5);
        logic [31:0] r;
        r        = 32'h0000_0013;
        r[14:12] = f3;
        r[30]    = b30;
        r[5]     = b5;
        return r;
    endfunction

    // Presents one op and returns #1 after the edge that accepted it (cycle T+1).
    task automatic send(input logic [4:0] ft, input logic [31:0] irw, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] pv);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n == 40) check("send_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; itype = ft; ir = irw; a = av; b = bv; pass = pv;
        tick();
        in_valid = 1'b0; itype = '0; ir = '0; a = '0; b = '0; pass = '0;
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1; in_valid = 1'b0; en4 = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; pass = '0; ir = '0; itype = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_pass", pass_out, 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        send(RTYPE, mk_ir(3'b000, 1'b0, 1'b1), 32'hFFFF_FFFF, 32'd1, 32'hAA);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_wrap", y, 32'h0000_0000);
        check("add_pass", pass_out, 32'hAA);
        send(RTYPE, mk_ir(3'b000, 1'b1, 1'b1), 32'd0, 32'd1, 32'hBB);
        check("sub", y, 32'hFFFF_FFFF);
        send(RTYPE, mk_ir(3'b010, 1'b0, 1'b1), 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("slt", y, 32'd1);
        send(RTYPE, mk_ir(3'b011, 1'b0, 1'b1), 32'hFFFF_FFFF, 32'd1, 32'h0);
        check("sltu", y, 32'd0);
        send(ITYPE, mk_ir(3'b000, 1'b1, 1'b0), 32'd5, 32'd3, 32'h0);
        check("addi_b30", y, 32'd8);
        send(RTYPE, mk_ir(3'b100, 1'b0, 1'b1), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("xor", y, 32'h0000_0FF0);
        send(ITYPE, mk_ir(3'b110, 1'b0, 1'b0), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("ori", y, 32'h0000_FFF0);
        send(RTYPE, mk_ir(3'b111, 1'b0, 1'b1), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("and", y, 32'h0000_F000);
        tick();

        // SRA by 4 (upper B bits set and ignored) on both step widths.
        en4 = 1'b1;
        send(RTYPE, mk_ir(3'b101, 1'b1, 1'b1), 32'h8000_0000, 32'hFFFF_FFE4, 32'h5A);
        en4 = 1'b0;
        check("sra_busy0", 32'(busy), 32'd1);
        check("sra4_busy0", 32'(busy4), 32'd1);
        check("sra4_valid_early", 32'(out_valid4), 32'd0);
        check("sra4_ready", 32'(in_ready4), 32'd0);
        tick();
        check("sra_busy1", 32'(busy), 32'd1);
        check("sra4_valid", 32'(out_valid4), 32'd1);
        check("sra4_y", y4, 32'hF800_0000);
        check("sra4_pass", pass_out4, 32'h5A);
        tick();
        check("sra_busy2", 32'(busy), 32'd1);
        tick();
        check("sra_busy3", 32'(busy), 32'd1);
        check("sra_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("sra_valid", 32'(out_valid), 32'd1);
        check("sra_busy_end", 32'(busy), 32'd0);
        check("sra_y", y, 32'hF800_0000);
        check("sra_pass", pass_out, 32'h5A);

        send(RTYPE, mk_ir(3'b001, 1'b0, 1'b1), 32'h0000_1234, 32'h0000_0020, 32'h0);
        check("sll0_valid", 32'(out_valid), 32'd1);
        check("sll0_busy", 32'(busy), 32'd0);
        check("sll0_y", y, 32'h0000_1234);
        tick();

        send(ITYPE, mk_ir(3'b101, 1'b0, 1'b0), 32'h8000_0000, 32'd2, 32'h0);
        wait_valid(20, cyc);
        check("srli_lat", 32'(cyc), 32'd2);
        check("srli_y", y, 32'h2000_0000);

        send(UTYPE, mk_ir(3'b000, 1'b0, 1'b1), 32'h0000_DEAD, 32'h1234_5000, 32'h11);
        check("lui", y, 32'h1234_5000);
        send(UTYPE, mk_ir(3'b000, 1'b0, 1'b0), 32'h0000_0100, 32'h0000_1000, 32'h77);
        check("auipc", y, 32'h0000_1100);
        check("auipc_pass", pass_out, 32'h77);
        tick();

        // Backpressure: result must hold while a second op waits at the input.
        out_ready = 1'b0;
        send(RTYPE, mk_ir(3'b000, 1'b0, 1'b1), 32'd10, 32'd20, 32'h55);
        in_valid = 1'b1; itype = RTYPE; ir = mk_ir(3'b000, 1'b0, 1'b1);
        a = 32'd1; b = 32'd1; pass = 32'h66;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_y", y, 32'd30);
            check("bp_pass", pass_out, 32'h55);
            check("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_next_y", y, 32'd2);
        check("bp_next_pass", pass_out, 32'h66);
        for (int k = 0; k < 4; k++) begin
            a = 32'(k * 16 + 1); b = 32'(k); pass = 32'(k);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_y", y, 32'(k * 17 + 1));
        end
        in_valid = 1'b0; a = '0; b = '0; pass = '0; ir = '0;
        tick();
        check("stream_drain", 32'(out_valid), 32'd0);

        // Reset in the middle of a long shift.
        send(RTYPE, mk_ir(3'b001, 1'b0, 1'b1), 32'd1, 32'd10, 32'h99);
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_y", y, 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        tick();
        check("mrst_no_output", 32'(out_valid), 32'd0);

        send(RTYPE, mk_ir(3'b000, 1'b0, 1'b1), 32'd7, 32'd8, 32'h1);
        check("post_add", y, 32'd15);
        tick();
        send(RTYPE, mk_ir(3'b101, 1'b0, 1'b1), 32'h0000_0100, 32'd4, 32'h2);
        wait_valid(20, cyc);
        check("post_srl_lat", 32'(cyc), 32'd4);
        check("post_srl_y", y, 32'h0000_0010);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
